// File: rtl/subtractor_reg.sv
// -----------------------------------------------------------------------------
// subtractor_reg
//   Registered N-bit two's-complement subtractor with carry/borrow-in.
//   Computes {cout,sum} = a + ~b + cin. With cin=1 this is a-b. With cin=0
//   it is a-b-1. The datapath is an explicit ripple of full-adder cells fed
//   with the inverted B operand. The result is registered, so latency is one
//   cycle. It is used for pointer-difference and occupancy arithmetic in the
//   CDC blocks.
//
// Parameters
//   N          operand / result width, 1..32
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   capture a, b, cin this cycle
//   a          minuend
//   b          subtrahend
//   cin        carry-in (1 = no borrow-in, 0 = borrow one)
//   sum        registered low N bits of a + ~b + cin
//   cout       registered carry-out (1 = no borrow)
//   out_valid  sum/cout hold a result captured from a valid input
// -----------------------------------------------------------------------------

// Single full-adder cell: one bit of the ripple chain.
module subtractor_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module subtractor_reg #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         out_valid
);

   logic [N-1:0] w_bn;   // inverted subtrahend
   logic [N:0]   w_c;    // ripple carries, w_c[N] is the carry-out
   logic [N-1:0] w_s;    // combinational difference

   logic [N-1:0] r_sum;
   logic         r_cout;
   logic         r_vld;

   assign w_bn   = ~b;
   assign w_c[0] = cin;

   // One cell per bit. The carry ripples from bit 0 up to bit N.
   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      subtractor_fa u_fa (
         .i_a (a[gi]),
         .i_b (w_bn[gi]),
         .i_c (w_c[gi]),
         .o_s (w_s[gi]),
         .o_c (w_c[gi+1])
      );
   end

   // Data registers load only on a valid input. That keeps the last result
   // stable and stops an idle or X-driven bus from reaching the outputs.
   // The valid flag follows in_valid every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_vld  <= 1'b0;
      end else begin
         r_vld <= in_valid;
         if (in_valid) begin
            r_sum  <= w_s;
            r_cout <= w_c[N];
         end
      end
   end

   assign sum       = r_sum;
   assign cout      = r_cout;
   assign out_valid = r_vld;

endmodule

// File: tb/tb_subtractor_reg.sv
// -----------------------------------------------------------------------------
// tb_subtractor_reg
//   Bench for subtractor_reg. It drives three instances (N=3, N=8 and N=1) in
//   lockstep. The N=3 instance gets directed vectors with hand-computed
//   results, then an exhaustive sweep. The N=8 and N=1 instances get random
//   traffic. Expected {cout,sum} values are queued when stimulus is driven
//   and popped when out_valid is due.
// -----------------------------------------------------------------------------
module tb_subtractor_reg;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       v3, c3, co3, ov3;
   logic [2:0] a3, b3, s3;
   logic       v8, c8, co8, ov8;
   logic [7:0] a8, b8, s8;
   logic       v1, c1, co1, ov1;
   logic [0:0] a1, b1, s1;

   subtractor_reg #(.N(3)) u_n3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .a(a3), .b(b3), .cin(c3),
      .sum(s3), .cout(co3), .out_valid(ov3));
   subtractor_reg #(.N(8)) u_n8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
      .sum(s8), .cout(co8), .out_valid(ov8));
   subtractor_reg #(.N(1)) u_n1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
      .sum(s1), .cout(co1), .out_valid(ov1));

   logic [3:0] q3[$];
   logic [8:0] q8[$];
   logic [1:0] q1[$];
   logic [3:0] h3;
   logic [8:0] h8;
   logic [1:0] h1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Reference model: a + (2^N-1-b) + cin at N+1 bits.
   function automatic logic [3:0] ref3(logic [2:0] a, logic [2:0] b, logic c);
      return {1'b0, a} + {1'b0, 3'd7 - b} + {3'd0, c};
   endfunction
   function automatic logic [8:0] ref8(logic [7:0] a, logic [7:0] b, logic c);
      return {1'b0, a} + {1'b0, 8'd255 - b} + {8'd0, c};
   endfunction
   function automatic logic [1:0] ref1(logic [0:0] a, logic [0:0] b, logic c);
      return {1'b0, a} + {1'b0, 1'b1 - b} + {1'b0, c};
   endfunction

   task automatic drv3(input logic v, input logic [2:0] a, input logic [2:0] b,
                       input logic c, input logic [3:0] e);
      v3 = v; a3 = a; b3 = b; c3 = c;
      if (v) q3.push_back(e);
   endtask

   task automatic rnd_others();
      v8 = ($urandom_range(0, 3) != 0); a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      v1 = ($urandom_range(0, 3) != 0); a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      if (v8) q8.push_back(ref8(a8, b8, c8));
      if (v1) q1.push_back(ref1(a1, b1, c1));
   endtask

   // Advance one clock and check every instance #1 after the edge.
   task automatic tick();
      logic p3, p8, p1;
      logic [3:0] e3;
      logic [8:0] e8;
      logic [1:0] e1;
      p3 = v3; p8 = v8; p1 = v1;
      @(posedge clk); #1;
      if (p3) begin e3 = (q3.size() > 0) ? q3.pop_front() : 4'bx; h3 = e3; end
      else e3 = h3;
      if (p8) begin e8 = (q8.size() > 0) ? q8.pop_front() : 9'bx; h8 = e8; end
      else e8 = h8;
      if (p1) begin e1 = (q1.size() > 0) ? q1.pop_front() : 2'bx; h1 = e1; end
      else e1 = h1;
      chk("n3_res", {5'd0, co3, s3}, {5'd0, e3});
      chk("n3_vld", {8'd0, ov3}, {8'd0, p3});
      chk("n8_res", {co8, s8}, e8);
      chk("n8_vld", {8'd0, ov8}, {8'd0, p8});
      chk("n1_res", {7'd0, co1, s1}, {7'd0, e1});
      chk("n1_vld", {8'd0, ov1}, {8'd0, p1});
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_n3"}, {4'd0, ov3, co3, s3}, 9'd0);
      chk({tag, "_n8"}, {ov8, co8, s8} , 10'd0 >> 1);
      chk({tag, "_n1"}, {6'd0, ov1, co1, s1}, 9'd0);
   endtask

   task automatic idle_all();
      v3 = 0; v8 = 0; v1 = 0;
      a3 = '0; b3 = '0; c3 = 0; a8 = '0; b8 = '0; c8 = 0; a1 = '0; b1 = '0; c1 = 0;
   endtask

   initial begin
      h3 = '0; h8 = '0; h1 = '0;
      rst_n = 1'b0;
      idle_all();
      @(posedge clk); #1;
      chk_zero("rst");
      #2 rst_n = 1'b1;
      tick();

      // Directed vectors with hand-computed results (cin=1, then cin=0).
      drv3(1, 3'b000, 3'b000, 1, 4'b1_000); rnd_others(); tick();
      drv3(1, 3'b000, 3'b001, 1, 4'b0_111); rnd_others(); tick();
      drv3(1, 3'b010, 3'b001, 1, 4'b1_001); rnd_others(); tick();
      drv3(1, 3'b101, 3'b000, 1, 4'b1_101); rnd_others(); tick();
      drv3(1, 3'b101, 3'b001, 1, 4'b1_100); rnd_others(); tick();
      drv3(1, 3'b101, 3'b101, 1, 4'b1_000); rnd_others(); tick();
      drv3(1, 3'b001, 3'b100, 0, 4'b0_100); rnd_others(); tick();
      drv3(1, 3'b001, 3'b111, 0, 4'b0_001); rnd_others(); tick();
      drv3(1, 3'b011, 3'b011, 0, 4'b0_111); rnd_others(); tick();

      // One idle cycle with garbage on the bus: outputs must hold.
      drv3(0, 3'b110, 3'b010, 1, 4'b0); rnd_others(); tick();
      drv3(1, 3'b111, 3'b010, 1, 4'b1_101); rnd_others(); tick();

      // Exhaustive back-to-back sweep of the N=3 instance.
      for (int i = 0; i < 128; i++) begin
         logic [2:0] ta, tb;
         logic       tc;
         ta = 3'(i >> 4); tb = 3'(i >> 1); tc = 1'(i);
         drv3(1, ta, tb, tc, ref3(ta, tb, tc));
         rnd_others();
         tick();
      end

      // Reset between edges clears immediately and drops the in-flight result.
      drv3(1, 3'b110, 3'b001, 1, ref3(3'b110, 3'b001, 1)); rnd_others();
      #2 rst_n = 1'b0;
      #1 chk_zero("rst_async");
      q3.delete(); q8.delete(); q1.delete();
      h3 = '0; h8 = '0; h1 = '0;
      @(posedge clk); #1;
      chk_zero("rst_hold");
      idle_all();
      #3 rst_n = 1'b1;
      tick();
      drv3(1, 3'b100, 3'b110, 1, 4'b0_110); rnd_others(); tick();

      // Random tail exercising all three widths.
      for (int i = 0; i < 200; i++) begin
         logic [2:0] ta, tb;
         logic       tc, tv;
         tv = ($urandom_range(0, 3) != 0);
         ta = 3'($urandom); tb = 3'($urandom); tc = 1'($urandom);
         drv3(tv, ta, tb, tc, ref3(ta, tb, tc));
         rnd_others();
         tick();
      end
      idle_all();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/subtractor_reg.md
Name: subtractor_reg

Overview:
- Parameterised N-bit two's-complement subtractor with carry/borrow-in.
- Computes a + ~b + cin, i.e. a - b when cin=1 and a - b - 1 when cin=0.
- Datapath is an explicit ripple chain of N full-adder cells, with the B operand inverted.
- Result and carry-out are registered (one-cycle latency) and qualified by a valid flag; used as the arithmetic primitive for pointer-difference / occupancy calculations in the CDC blocks.

Parameters:
- N, 3, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle; capture a, b, cin.
- a  input  N  minuend (unsigned or two's complement; identical bit behaviour).
- b  input  N  subtrahend.
- cin  input  1  carry-in; 1 = no borrow-in (plain a-b), 0 = borrow-in of 1.
- sum  output  N  registered difference, low N bits of a + ~b + cin.
- cout  output  1  registered carry-out (bit N); 1 = no borrow (a >= b + !cin, unsigned), 0 = borrow.
- out_valid  output  1  sum/cout hold a result captured from a valid input.

Behaviour:
- Combinational core: bit i computes s_i = a_i ^ ~b_i ^ c_i and c_{i+1} = majority(a_i, ~b_i, c_i), with c_0 = cin. Result = s[N-1:0], carry = c_N.
- Equivalently, {cout,sum} = a + (2^N-1-b) + cin, evaluated at N+1 bits with no truncation before bit N.
- Registers:
  - On a rising clk edge with in_valid=1: sum and cout take the core result, out_valid <= 1.
  - On a rising clk edge with in_valid=0: sum and cout hold their previous values, out_valid <= 0.
- Latency is exactly 1 cycle from an in_valid sample to the matching out_valid. Full throughput: one result per cycle, no backpressure.
- Reset: rst_n low asynchronously forces sum=0, cout=0 and out_valid=0, regardless of clk. Release is synchronous to the next clk edge. Reset mid-stream discards the in-flight result; the first valid input after release appears one cycle later.
- Wrap-around: the result is modulo 2^N. Underflow (a < b with cin=1) wraps, e.g. 0-1 = all ones with cout=0.
- a==b with cin=1 gives sum=0, cout=1. a==b with cin=0 gives sum = all ones, cout=0.
- No X propagation from an idle bus: inputs are ignored when in_valid=0.
- No overflow flag; signed overflow detection is the consumer's responsibility.

Test Plan:
- N=3, reset asserted, then released -> sum=000, cout=0, out_valid=0. Reset asserted between clock edges clears the outputs immediately.
- Basic set with cin=1, in_valid=1, each checked one cycle later:
  - a=000 b=000 -> sum=000 cout=1
  - a=000 b=001 -> sum=111 cout=0
  - a=010 b=001 -> sum=001 cout=1
  - a=101 b=000 -> sum=101 cout=1
  - a=101 b=001 -> sum=100 cout=1
  - a=101 b=101 -> sum=000 cout=1
- Borrow-in with cin=0:
  - a=001 b=100 -> sum=100 cout=0
  - a=001 b=111 -> sum=001 cout=0
- Back-to-back valid inputs every cycle -> one result per cycle in order, out_valid continuously 1. Dropping in_valid for one cycle -> out_valid=0 that cycle and sum/cout held.
- Exhaustive sweep for N=3 (all a, b, cin) against a reference model {cout,sum} = a + ~b + cin; repeat a random sweep at N=8 and N=1.
